// File: rtl/ibuf_pkg.sv
// ibuf_pkg: shared sizes and FSM state type for the instruction buffer controller
package ibuf_pkg;
    localparam int IBUF_DEPTH = 64;
    localparam int IBUF_AW = $clog2(IBUF_DEPTH);
    localparam int FETCH_NUM = 4;
    localparam int DECODE_NUM = 4;
    localparam int TAKE_W = $clog2(DECODE_NUM + 1);
    localparam int FETCH_W = $clog2(FETCH_NUM + 1);
    typedef enum logic {INIT, RUN} ibuf_state_e;
endpackage

// File: rtl/instr_buffer_ctrl_if.sv
// instr_buffer_ctrl_if: fetch/decode/buffer-array signals of the instruction buffer controller
interface instr_buffer_ctrl_if import ibuf_pkg::*; ();
    logic                  fetch_valid;
    logic                  fetch_ready;
    logic                  buf_wr_en;
    logic [IBUF_AW-1:0]    buf_wr_addr;
    logic [IBUF_AW-1:0]    buf_rd_addr;
    logic [DECODE_NUM-1:0] dec_valid;
    logic [TAKE_W-1:0]     dec_take;
    logic                  flush;
    logic [IBUF_AW:0]      occupancy;
    logic                  empty;
    logic                  full;
    modport master (
        output fetch_valid, dec_take, flush,
        input  fetch_ready, buf_wr_en, buf_wr_addr, buf_rd_addr, dec_valid, occupancy, empty, full
    );
    modport slave (
        input  fetch_valid, dec_take, flush,
        output fetch_ready, buf_wr_en, buf_wr_addr, buf_rd_addr, dec_valid, occupancy, empty, full
    );
endinterface

// File: rtl/ibuf_ptr.sv
// ibuf_ptr: wrap-bit pointer with synchronous clear and per-cycle advance amount
module ibuf_ptr import ibuf_pkg::*; #(
    parameter int W = IBUF_AW + 1,
    parameter int AMT_W = TAKE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [AMT_W-1:0] amt,
    output logic [W-1:0]     ptr
);
    logic [W-1:0] ptr_d, ptr_q;
    always_comb ptr_d = clr ? '0 : ptr_q + W'(amt);
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end
    assign ptr = ptr_q;
endmodule

// File: rtl/instr_buffer_ctrl.sv
// instr_buffer_ctrl: pointer, occupancy, backpressure and flush control for the fetch-to-decode instruction buffer
module instr_buffer_ctrl import ibuf_pkg::*; (
    input logic               clk,
    input logic               rst,
    instr_buffer_ctrl_if.slave bus
);
    localparam int PW = IBUF_AW + 1;
    ibuf_state_e state_q, state_d;
    logic [PW-1:0]         wr_ptr, rd_ptr, occ;
    logic                  run, ready, wr_en;
    logic [TAKE_W-1:0]     avail, eff_take;
    logic [FETCH_W-1:0]    wr_amt;
    logic [DECODE_NUM-1:0] dec_valid;
    always_comb begin
        state_d = bus.flush ? INIT : RUN;
        run = state_q == RUN;
        occ = wr_ptr - rd_ptr;
        ready = run && occ <= PW'(IBUF_DEPTH - FETCH_NUM);
        avail = !run ? '0 : occ >= PW'(DECODE_NUM) ? TAKE_W'(DECODE_NUM) : TAKE_W'(occ);
        eff_take = bus.flush ? '0 : bus.dec_take > avail ? avail : bus.dec_take;
        wr_en = bus.fetch_valid && ready && !bus.flush;
        wr_amt = wr_en ? FETCH_W'(FETCH_NUM) : '0;
        dec_valid = '0;
        for (int i = 0; i < DECODE_NUM; i++) dec_valid[i] = run && occ > PW'(i);
    end
    always_ff @(posedge clk) begin
        if (rst) state_q <= INIT;
        else state_q <= state_d;
    end
    ibuf_ptr #(.W(PW), .AMT_W(FETCH_W)) u_wr_ptr (
        .clk(clk), .rst(rst), .clr(bus.flush), .amt(wr_amt), .ptr(wr_ptr)
    );
    ibuf_ptr #(.W(PW), .AMT_W(TAKE_W)) u_rd_ptr (
        .clk(clk), .rst(rst), .clr(bus.flush), .amt(eff_take), .ptr(rd_ptr)
    );
    assign bus.fetch_ready = ready;
    assign bus.buf_wr_en = wr_en;
    assign bus.buf_wr_addr = wr_ptr[IBUF_AW-1:0];
    assign bus.buf_rd_addr = rd_ptr[IBUF_AW-1:0];
    assign bus.dec_valid = dec_valid;
    assign bus.occupancy = occ;
    assign bus.empty = occ == '0;
    assign bus.full = occ == PW'(IBUF_DEPTH);
    over_take_a: assert property (@(posedge clk) disable iff (rst) !(run && !bus.flush && bus.dec_take > avail));
endmodule

// File: tb/tb_instr_buffer_ctrl.sv
// tb_instr_buffer_ctrl: scoreboard bench for instr_buffer_ctrl with a reference pointer model
module tb_instr_buffer_ctrl;
    import ibuf_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_err = 0;
    int m_wr = 0;
    int m_rd = 0;
    bit m_run = 1'b0;
    int wr_q[$];
    int slot_q[$];
    instr_buffer_ctrl_if bus();
    instr_buffer_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask
    task automatic cyc(input bit r, input bit fv, input int take, input bit fl);
        int occ, avail, t, eff;
        bit rdy, wen;
        @(negedge clk);
        occ = (m_wr - m_rd) & 127;
        avail = m_run ? (occ >= 4 ? 4 : occ) : 0;
        t = r ? 0 : (take > avail ? avail : take);
        rst = r;
        bus.fetch_valid = fv;
        bus.dec_take = TAKE_W'(t);
        bus.flush = fl;
        rdy = m_run && occ <= IBUF_DEPTH - FETCH_NUM;
        wen = fv && rdy && !fl && !r;
        eff = (fl || r) ? 0 : t;
        if (wen) begin
            wr_q.push_back(m_wr % 64);
            for (int i = 0; i < FETCH_NUM; i++) slot_q.push_back((m_wr + i) % 64);
        end
        #1;
        if (!r) begin
            check("occupancy", int'(bus.occupancy), occ);
            check("fetch_ready", int'(bus.fetch_ready), int'(rdy));
            check("dec_valid", int'(bus.dec_valid), m_run ? (1 << avail) - 1 : 0);
            check("empty", int'(bus.empty), int'(occ == 0));
            check("full", int'(bus.full), int'(occ == 64));
            check("rd_addr", int'(bus.buf_rd_addr), m_rd % 64);
            check("wr_en", int'(bus.buf_wr_en), int'(wen));
            if (bus.buf_wr_en) begin
                if (wr_q.size() == 0) check("wr_q_empty", 1, 0);
                else check("wr_addr", int'(bus.buf_wr_addr), wr_q.pop_front());
            end
            for (int i = 0; i < eff; i++) begin
                if (slot_q.size() == 0) check("slot_q_empty", 1, 0);
                else check("slot", (int'(bus.buf_rd_addr) + i) % 64, slot_q.pop_front());
            end
        end
        if (r || fl) begin
            m_run = 1'b0;
            m_wr = 0;
            m_rd = 0;
            wr_q.delete();
            slot_q.delete();
        end else begin
            m_run = 1'b1;
            m_wr = (m_wr + (wen ? FETCH_NUM : 0)) & 127;
            m_rd = (m_rd + eff) & 127;
        end
    endtask
    initial begin
        bus.fetch_valid = 1'b0;
        bus.dec_take = '0;
        bus.flush = 1'b0;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (17) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (16) cyc(0, 0, 4, 0);
        cyc(0, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0);
        cyc(0, 0, 2, 0);
        cyc(0, 0, 4, 0);
        cyc(0, 0, 0, 0);
        repeat (15) cyc(0, 1, 0, 0);
        cyc(0, 0, 2, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 3, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        repeat (16) cyc(0, 1, 0, 0);
        repeat (15) cyc(0, 0, 4, 0);
        cyc(0, 0, 2, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 4, 0);
        cyc(0, 0, 2, 0);
        cyc(0, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0);
        cyc(0, 1, 2, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (400) cyc(0, bit'($urandom_range(0, 2) != 0), int'($urandom_range(0, 4)), bit'($urandom_range(0, 60) == 0));
        cyc(0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
